// File: rtl/rx_fifo_wr_ctrl.sv
// ============================================================================
// rx_fifo_wr_ctrl : packet write sequencer from rx MAC AXI-Stream into the
//                   rx async FIFO (commit / rewind / drop statistics).
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module rx_fifo_wr_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_PKT_BEATS = 1518,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  latch_addr,
  output logic                  drop_pckt,
  output logic [CNT_WIDTH-1:0]  good_cnt,
  output logic [CNT_WIDTH-1:0]  crc_drop_cnt,
  output logic [CNT_WIDTH-1:0]  ovf_drop_cnt,
  output logic [CNT_WIDTH-1:0]  size_drop_cnt
);

  localparam int                   BC_W        = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [BC_W-1:0]      C_MAX_BEATS = BC_W'(MAX_PKT_BEATS);
  localparam logic [BC_W-1:0]      C_BC_ONE    = BC_W'(1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [BC_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic            w_write, w_latch, w_drop;
  logic            w_inc_good, w_inc_crc, w_inc_ovf, w_inc_size;
  logic [CNT_WIDTH-1:0] r_good_cnt, r_crc_cnt, r_ovf_cnt, r_size_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_write        = 1'b0;
    w_latch        = 1'b0;
    w_drop         = 1'b0;
    w_inc_good     = 1'b0;
    w_inc_crc      = 1'b0;
    w_inc_ovf      = 1'b0;
    w_inc_size     = 1'b0;
    if (s_axis_tvalid) begin
      case (r_state)
        S_IDLE: begin
          // Nothing of this frame is in the FIFO yet, so an overflow needs no rewind
          if (fifo_almost_full) begin
            w_inc_ovf   = 1'b1;
            w_state_nxt = s_axis_tlast ? S_IDLE : S_DISCARD;
          end else if (s_axis_tuser) begin
            w_drop      = 1'b1;
            w_inc_crc   = 1'b1;
            w_state_nxt = s_axis_tlast ? S_IDLE : S_DISCARD;
          end else if (s_axis_tlast) begin
            w_write     = 1'b1;
            w_latch     = 1'b1;
            w_inc_good  = 1'b1;
          end else begin
            w_write        = 1'b1;
            w_beat_cnt_nxt = C_BC_ONE;
            w_state_nxt    = S_WRITE;
          end
        end
        S_WRITE: begin
          if (fifo_full || (r_beat_cnt == C_MAX_BEATS) || s_axis_tuser) begin
            w_drop      = 1'b1;
            w_inc_ovf   = fifo_full;
            w_inc_size  = !fifo_full && (r_beat_cnt == C_MAX_BEATS);
            w_inc_crc   = !fifo_full && (r_beat_cnt != C_MAX_BEATS);
            w_state_nxt = s_axis_tlast ? S_IDLE : S_DISCARD;
          end else if (s_axis_tlast) begin
            w_write     = 1'b1;
            w_latch     = 1'b1;
            w_inc_good  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_write        = 1'b1;
            w_beat_cnt_nxt = r_beat_cnt + C_BC_ONE;
          end
        end
        S_DISCARD: begin
          if (s_axis_tlast) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_state_nxt == S_IDLE) w_beat_cnt_nxt = '0;
  end

  // Strobes are held low while in reset even if the MAC keeps streaming
  assign fifo_write = w_write & reset_n;
  assign latch_addr = w_latch & reset_n;
  assign drop_pckt  = w_drop  & reset_n;
  assign fifo_wdata = s_axis_tdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_good_cnt <= '0;
      r_crc_cnt  <= '0;
      r_ovf_cnt  <= '0;
      r_size_cnt <= '0;
    end else begin
      if (w_inc_good && (r_good_cnt != C_CNT_MAX)) r_good_cnt <= r_good_cnt + C_CNT_ONE;
      if (w_inc_crc  && (r_crc_cnt  != C_CNT_MAX)) r_crc_cnt  <= r_crc_cnt  + C_CNT_ONE;
      if (w_inc_ovf  && (r_ovf_cnt  != C_CNT_MAX)) r_ovf_cnt  <= r_ovf_cnt  + C_CNT_ONE;
      if (w_inc_size && (r_size_cnt != C_CNT_MAX)) r_size_cnt <= r_size_cnt + C_CNT_ONE;
    end
  end

  assign good_cnt      = r_good_cnt;
  assign crc_drop_cnt  = r_crc_cnt;
  assign ovf_drop_cnt  = r_ovf_cnt;
  assign size_drop_cnt = r_size_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo_wr_ctrl.sv
// ============================================================================
// tb_rx_fifo_wr_ctrl : vector/scoreboard bench for rx_fifo_wr_ctrl, run on a
//                      full-size instance and a small (16 beat, 2-bit) one.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rx_fifo_wr_ctrl;

  localparam int MAXA = 1518;
  localparam int MAXB = 16;

  typedef struct packed {
    logic             rst_n, valid, last, user, full, afull;
    logic [7:0]       data;
    logic [2:0]       ea, eb;   // {write, latch, drop}
    logic [3:0][15:0] ca;       // good, crc, ovf, size after this cycle
    logic [3:0][1:0]  cb;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n, tvalid, tlast, tuser, full, afull;
  logic [7:0] tdata;
  logic a_wr, a_la, a_dr, b_wr, b_la, b_dr;
  logic [7:0] a_wd, b_wd;
  logic [15:0] a_good, a_crc, a_ovf, a_size;
  logic [1:0]  b_good, b_crc, b_ovf, b_size;

  int tests = 0;
  int fails = 0;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   m_cnt[2][4];
  int   m_st[2];      // 0 idle, 1 write, 2 discard
  int   m_bc[2];

  always #5 clk = ~clk;

  rx_fifo_wr_ctrl #(.DATA_WIDTH(8), .MAX_PKT_BEATS(MAXA), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .fifo_full(full), .fifo_almost_full(afull),
    .fifo_write(a_wr), .fifo_wdata(a_wd), .latch_addr(a_la), .drop_pckt(a_dr),
    .good_cnt(a_good), .crc_drop_cnt(a_crc), .ovf_drop_cnt(a_ovf), .size_drop_cnt(a_size));

  rx_fifo_wr_ctrl #(.DATA_WIDTH(8), .MAX_PKT_BEATS(MAXB), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .fifo_full(full), .fifo_almost_full(afull),
    .fifo_write(b_wr), .fifo_wdata(b_wd), .latch_addr(b_la), .drop_pckt(b_dr),
    .good_cnt(b_good), .crc_drop_cnt(b_crc), .ovf_drop_cnt(b_ovf), .size_drop_cnt(b_size));

  task automatic bump(input int i, input int k);
    int sat;
    sat = (i == 0) ? 65535 : 3;
    if (m_cnt[i][k] < sat) m_cnt[i][k]++;
  endtask

  task automatic snap(inout vec_t v);
    for (int k = 0; k < 4; k++) begin
      v.ca[k] = 16'(m_cnt[0][k]);
      v.cb[k] = 2'(m_cnt[1][k]);
    end
  endtask

  task automatic add_reset();
    vec_t v;
    v = '0;
    v.valid = 1'b1;
    v.data  = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0;
      m_bc[i] = 0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
    end
    snap(v);
    tbl.push_back(v);
  endtask

  task automatic add_gap();
    vec_t v;
    v = '0;
    v.rst_n = 1'b1;
    v.last  = 1'($urandom);
    v.user  = 1'($urandom);
    v.full  = 1'($urandom);
    v.afull = 1'($urandom);
    v.data  = 8'($urandom);
    snap(v);
    tbl.push_back(v);
  endtask

  // Frame of len beats: tuser on beat bad, fifo_full on beat full_at, almost_full
  // on the first beat if af; only the first cut beats are emitted.
  task automatic add_frame(input int len, input int bad, input int full_at,
                           input bit af, input int cut, input int gap);
    for (int b = 1; b <= cut; b++) begin
      vec_t v;
      logic [2:0] e[2];
      v = '0;
      v.rst_n = 1'b1;
      v.valid = 1'b1;
      v.last  = (b == len);
      v.user  = (b == bad);
      v.full  = (b == full_at);
      v.afull = af && (b == 1);
      v.data  = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        int mx;
        mx   = (i == 0) ? MAXA : MAXB;
        e[i] = 3'b000;
        if (m_st[i] == 0) begin
          if (v.afull) begin
            bump(i, 2); m_st[i] = v.last ? 0 : 2;
          end else if (v.user) begin
            e[i] = 3'b001; bump(i, 1); m_st[i] = v.last ? 0 : 2;
          end else if (v.last) begin
            e[i] = 3'b110; bump(i, 0);
          end else begin
            e[i] = 3'b100; m_bc[i] = 1; m_st[i] = 1;
          end
        end else if (m_st[i] == 1) begin
          if (v.full || m_bc[i] == mx || v.user) begin
            e[i] = 3'b001;
            bump(i, v.full ? 2 : (m_bc[i] == mx) ? 3 : 1);
            m_st[i] = v.last ? 0 : 2;
          end else if (v.last) begin
            e[i] = 3'b110; bump(i, 0); m_st[i] = 0;
          end else begin
            e[i] = 3'b100; m_bc[i]++;
          end
        end else if (v.last) begin
          m_st[i] = 0;
        end
      end
      v.ea = e[0];
      v.eb = e[1];
      snap(v);
      tbl.push_back(v);
      if (gap > 0 && (b % gap) == 0 && b != cut) add_gap();
    end
  endtask

  initial begin
    vec_t cur;
    reset_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    full = 1'b0; afull = 1'b0; tdata = '0;

    add_reset(); add_reset();
    add_frame(64, 0,  0,  0, 64, 0);   // good 64 (small instance: oversize at 17)
    add_frame(64, 64, 0,  0, 64, 0);   // tuser on last beat
    add_frame(64, 10, 0,  0, 64, 0);   // tuser on beat 10
    add_frame(8,  0,  0,  0, 8,  3);   // next frame accepted, idle cycles inside
    add_frame(64, 0,  20, 0, 64, 5);   // fifo_full at beat 20, gaps during discard
    add_frame(8,  0,  0,  1, 8,  0);   // almost_full at frame start
    add_frame(20, 0,  0,  0, 20, 0);   // oversize on the small instance
    add_frame(16, 0,  0,  0, 16, 0);   // exactly the small limit
    add_frame(17, 0,  0,  0, 17, 0);   // oversize beat is also tlast
    add_frame(18, 0,  18, 0, 18, 0);   // full on the last beat
    add_reset();
    add_frame(1, 0, 0, 0, 1, 0);       // back-to-back frames, counter saturation
    add_frame(2, 0, 0, 0, 2, 0);
    add_frame(1, 0, 0, 0, 1, 0);
    add_frame(3, 0, 0, 0, 3, 0);
    add_frame(1, 0, 0, 0, 1, 0);
    add_frame(1, 0, 0, 1, 1, 0);       // single beat under almost_full
    add_frame(1, 1, 0, 0, 1, 0);       // single bad beat
    add_frame(4, 0, 0, 0, 4, 2);
    add_frame(10, 0, 0, 0, 6, 0);      // reset mid-frame, rest seen as a new frame
    add_reset();
    add_frame(4, 0, 0, 0, 4, 0);
    add_frame(3, 0, 2, 0, 3, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      logic ok;
      @(negedge clk);
      reset_n = tbl[n].rst_n; tvalid = tbl[n].valid; tlast = tbl[n].last;
      tuser = tbl[n].user; full = tbl[n].full; afull = tbl[n].afull; tdata = tbl[n].data;
      exp_q.push_back(tbl[n]);
      #1;
      cur = exp_q[0];
      tests++;
      ok = ({a_wr, a_la, a_dr} == cur.ea) && (!cur.ea[2] || a_wd == cur.data);
      if (!ok) begin
        fails++;
        $display("FAIL strobe_a vec %0d: got wld=%b wdata=%h, expected wld=%b wdata=%h",
                 n, {a_wr, a_la, a_dr}, a_wd, cur.ea, cur.data);
      end
      tests++;
      ok = ({b_wr, b_la, b_dr} == cur.eb) && (!cur.eb[2] || b_wd == cur.data);
      if (!ok) begin
        fails++;
        $display("FAIL strobe_b vec %0d: got wld=%b wdata=%h, expected wld=%b wdata=%h",
                 n, {b_wr, b_la, b_dr}, b_wd, cur.eb, cur.data);
      end
      @(posedge clk);
      #1;
      cur = exp_q.pop_front();
      tests++;
      if ({a_good, a_crc, a_ovf, a_size} != {cur.ca[0], cur.ca[1], cur.ca[2], cur.ca[3]}) begin
        fails++;
        $display("FAIL counters_a vec %0d: got g/c/o/s=%0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                 n, a_good, a_crc, a_ovf, a_size, cur.ca[0], cur.ca[1], cur.ca[2], cur.ca[3]);
      end
      tests++;
      if ({b_good, b_crc, b_ovf, b_size} != {cur.cb[0], cur.cb[1], cur.cb[2], cur.cb[3]}) begin
        fails++;
        $display("FAIL counters_b vec %0d: got g/c/o/s=%0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                 n, b_good, b_crc, b_ovf, b_size, cur.cb[0], cur.cb[1], cur.cb[2], cur.cb[3]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_fifo_wr_ctrl.md
# rx_fifo_wr_ctrl

Packet-level write sequencer between the rx MAC AXI-Stream output and the write port of the rx asynchronous FIFO. It forwards accepted beats as FIFO writes. It commits each good frame by pulsing `latch_addr` on its last beat. It rewinds partially written frames with `drop_pckt` on CRC/error, overflow or oversize. It maintains saturating per-cause packet counters.

## Interface
- `DATA_WIDTH`, 8, beat width
- `MAX_PKT_BEATS`, 1518, max beats per frame; beat `MAX_PKT_BEATS+1` is oversize
- `CNT_WIDTH`, 16, statistics counter width
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `s_axis_tdata`  in  DATA_WIDTH  rx beat data
- `s_axis_tvalid`  in  1  beat valid; no backpressure, every valid beat is consumed
- `s_axis_tlast`  in  1  last beat of frame
- `s_axis_tuser`  in  1  bad frame (CRC/PHY error), valid on any beat
- `fifo_full`  in  1  FIFO full flag (registered, write clock domain)
- `fifo_almost_full`  in  1  FIFO almost-full flag
- `fifo_write`  out  1  write strobe to FIFO
- `fifo_wdata`  out  DATA_WIDTH  equals `s_axis_tdata`
- `latch_addr`  out  1  commit pulse; coincides with the good last beat's write
- `drop_pckt`  out  1  rewind pulse; write pointer returns to last commit
- `good_cnt`, `crc_drop_cnt`, `ovf_drop_cnt`, `size_drop_cnt`  out  CNT_WIDTH each  saturating counters

## Operation
- FSM states: IDLE (awaiting first beat), WRITE (mid-frame), DISCARD (swallow to tlast, no writes, no pulses, no counts).
- All FIFO outputs are combinational from the current beat, state and flags. State, beat counter and statistics counters are registered.
- IDLE, valid beat:
  - `fifo_almost_full`=1: no write, no drop_pckt (nothing written), `ovf_drop_cnt`+1. tlast → stay IDLE; else → DISCARD.
  - Else, tuser=1: no write, `drop_pckt`=1, `crc_drop_cnt`+1. tlast → IDLE; else → DISCARD.
  - Else, tlast=1: write + `latch_addr`, `good_cnt`+1, stay IDLE.
  - Else: write, beat_cnt←1, → WRITE.
- WRITE, valid beat, priority high→low:
  - `fifo_full`: no write, drop_pckt, ovf+1.
  - beat_cnt==MAX_PKT_BEATS: no write, drop_pckt, size+1.
  - tuser: no write, drop_pckt, crc+1.
  - tlast: write+latch, good+1 → IDLE.
  - else: write, beat_cnt+1.
- For the three drop cases: tlast → IDLE; else → DISCARD.
- DISCARD: beats ignored; tlast → IDLE.
- `fifo_write`, `latch_addr`, `drop_pckt` are never asserted without `s_axis_tvalid`. `drop_pckt` and `fifo_write` are mutually exclusive. `latch_addr` implies `fifo_write`.
- At most one counter increments per cycle. Counters hold at 2^CNT_WIDTH−1.
- beat_cnt width is $clog2(MAX_PKT_BEATS+1). It saturates and is cleared on IDLE entry.

## Timing
- Zero latency: write/latch/drop asserted in the same cycle as the accepted beat. The FIFO samples them on that edge.
- `fifo_full` reflects writes up to the previous edge and is sufficient because the FIFO also gates write with full.
- Invalid cycles (tvalid=0) hold state; no outputs asserted.
- Reset: state IDLE, beat_cnt 0, all counters 0, all strobes 0.
- Reset mid-frame: the remaining beats of that frame are treated as a new frame from IDLE. The FIFO is reset concurrently, so no rewind is required.
- A single-beat frame is completed entirely in IDLE.
- Back-to-back frames (tlast then new first beat the next cycle) require no idle cycle.

## Test plan
- Good 64-beat frame, FIFO empty → 64 `fifo_write`, `latch_addr` only on beat 64, good_cnt=1, no drop_pckt.
- 64-beat frame with tuser on beat 64 → 63 writes, drop_pckt on beat 64 only, crc_drop_cnt=1, good_cnt unchanged.
- tuser on beat 10 of a 64-beat frame → 9 writes, drop_pckt on beat 10, no activity beats 11–64, next frame accepted normally.
- Force fifo_full at beat 20 → drop_pckt on beat 20, DISCARD to tlast, ovf_drop_cnt=1. Frame start with almost_full=1 → zero writes, no drop_pckt, ovf_drop_cnt=2.
- MAX_PKT_BEATS=16, 20-beat frame → 16 writes, drop_pckt on beat 17, size_drop_cnt=1. A 16-beat frame with the same setting → committed.
- CNT_WIDTH=2, five good frames → good_cnt saturates at 3. Reset asserted mid-frame → all counters 0, state IDLE.
